// File: rtl/spm_seq_ctrl_if.sv
// Operand/product handshake bundle for the spm sequencer.
// master = issue/consume side, slave = spm_seq_ctrl.
interface spm_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_prod
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_prod
  );
endinterface

// File: rtl/spm_seq_ctrl.sv
// Sequencer for the serial-parallel multiplier CSA chain.
// Ports: clk, rst (sync, active-low), bus (operand in / product out),
//   spm_x/spm_y/spm_clr_n to the array, spm_p from it, busy status.
module spm_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int P_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  spm_seq_ctrl_if.slave    bus,
  output logic [WIDTH-1:0] spm_x,
  output logic             spm_y,
  output logic             spm_clr_n,
  input  logic             spm_p,
  output logic             busy
);

  localparam int PW   = 2 * WIDTH;
  localparam int NRUN = PW + P_LAT;
  localparam int CW   = $clog2(NRUN + 1);

  localparam logic [CW-1:0] LAST = CW'(NRUN - 1);
  localparam logic [CW-1:0] PL   = CW'(P_LAT);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    prod_q;
  logic [PW-1:0]    out_q;
  logic             rdy_q;
  logic             busy_q;
  logic             ov_q;
  logic             clrn_q;
  logic             y_q;

  logic [WIDTH-1:0] b_d;
  logic [PW-1:0]    prod_d;

  // b_q doubles as an arithmetic shift register, so once the
  // real bits run out its LSB keeps presenting the sign bit.
  assign b_d    = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
  assign prod_d = {spm_p, prod_q[PW-1:1]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      ov_q    <= 1'b0;
      clrn_q  <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            state_q <= CLEAR;
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            prod_q  <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          state_q <= RUN;
          clrn_q  <= 1'b1;
          y_q     <= b_q[0];
          b_q     <= b_d;
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          y_q   <= b_q[0];
          b_q   <= b_d;
          // spm_p trails spm_y by P_LAT cycles
          if (cnt_q >= PL) begin
            prod_q <= prod_d;
          end
          if (cnt_q == LAST) begin
            state_q <= DONE;
            out_q   <= prod_d;
            busy_q  <= 1'b0;
            clrn_q  <= 1'b0;
            ov_q    <= 1'b1;
            y_q     <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
            rdy_q   <= 1'b1;
            out_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = ov_q;
  assign bus.out_prod  = out_q;
  assign spm_x         = a_q;
  assign spm_y         = y_q;
  assign spm_clr_n     = clrn_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_spm_seq_ctrl.sv
// Scoreboard bench for spm_seq_ctrl with a behavioural spm array.
// Expected products are plain signed multiplies queued at accept.
module tb_spm_seq_ctrl;
  localparam int W  = 8;
  localparam int PL = 1;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spm_seq_ctrl_if #(.WIDTH(W)) bus ();

  logic [W-1:0] spm_x;
  logic         spm_y;
  logic         spm_clr_n;
  logic         spm_p;
  logic         busy;

  spm_seq_ctrl #(
    .WIDTH(W),
    .P_LAT(PL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .spm_x    (spm_x),
    .spm_y    (spm_y),
    .spm_clr_n(spm_clr_n),
    .spm_p    (spm_p),
    .busy     (busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at cyc %0d",
               nm, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural spm: product bit k of x*Y only depends on the
  // first k+1 serial multiplier bits; one register of latency.
  int          k_m = 0;
  logic [63:0] yb_m = '0;
  longint      pr_m;
  always @(posedge clk) begin
    if (!spm_clr_n) begin
      k_m  = 0;
      yb_m = '0;
      spm_p <= 1'b0;
    end else begin
      if (k_m < 64) yb_m[k_m] = spm_y;
      pr_m = longint'($signed(spm_x)) * longint'(yb_m);
      spm_p <= (k_m < 64) ? pr_m[k_m] : 1'b0;
      k_m = k_m + 1;
    end
  end

  // Scoreboard monitor
  logic [PW-1:0] expq[$];
  int            accq[$];
  logic          ov_prev = 1'b0;
  logic          hs_prev = 1'b0;
  logic [PW-1:0] held    = '0;

  always @(negedge clk) begin
    if (!rst) begin
      expq.delete();
      accq.delete();
      ov_prev = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        int p;
        p = int'($signed(bus.in_a)) * int'($signed(bus.in_b));
        expq.push_back(PW'(p));
        accq.push_back(cyc + 1);
      end
      if (hs_prev) begin
        chk("ov_one_cycle", 32'(bus.out_valid), 0);
        chk("rdy_after_hs", 32'(bus.in_ready), 1);
      end
      if (bus.out_valid && !ov_prev) begin
        if (accq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: got 1 want 0 at cyc %0d",
                   cyc);
        end else begin
          chk("latency", 32'(cyc - accq[0]), 32'(2*W + PL + 2 - 1));
        end
      end
      if (bus.out_valid && ov_prev && !hs_prev) begin
        chk("prod_hold", 32'(bus.out_prod), 32'(held));
      end
      if (bus.out_valid && bus.out_ready && expq.size() > 0) begin
        chk("product", 32'(bus.out_prod), 32'(expq.pop_front()));
        void'(accq.pop_front());
      end
      ov_prev = bus.out_valid;
      hs_prev = bus.out_valid && bus.out_ready;
      held    = bus.out_prod;
    end
  end

  task automatic idle_chk(string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_clr_n"}, 32'(spm_clr_n), 0);
    chk({tag, "_spm_x"}, 32'(spm_x), 0);
    chk({tag, "_spm_y"}, 32'(spm_y), 0);
    chk({tag, "_out_prod"}, 32'(bus.out_prod), 0);
  endtask

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_timeout", 32'(bus.in_ready), 1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
  endtask

  task automatic do_op(logic [W-1:0] a, logic [W-1:0] b, int hold);
    int n = 0;
    bus.out_ready = (hold == 0);
    issue(a, b);
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("out_valid_timeout", 32'(bus.out_valid), 1);
    for (int i = 0; i < hold; i++) begin
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      bus.in_valid = 1'($urandom);
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle_chk("in_reset");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      idle_chk("idle");
    end
    @(posedge clk); #1;

    do_op(8'd3, 8'd5, 0);
    do_op(8'hFD, 8'd5, 0);
    do_op(8'h80, 8'h80, 0);
    do_op(8'h7F, 8'h80, 0);
    do_op(8'h81, 8'h7F, 5);
    repeat (2) @(posedge clk);
    #1;
    idle_chk("after_bp");

    // reset pulse at RUN c=6
    issue(8'h55, 8'h33);
    repeat (7) @(posedge clk);
    #1;
    chk("busy_mid_run", 32'(busy), 1);
    chk("clr_n_mid_run", 32'(spm_clr_n), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle_chk("post_rst");
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(bus.out_valid), 0);
    end
    @(posedge clk); #1;
    do_op(8'd2, 8'd2, 0);

    for (int i = 0; i < 30; i++) begin
      do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 4)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", 32'(expq.size()), 0);
    idle_chk("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
